// File: rtl/watchdog_reset_req.sv
// watchdog_reset_req: kick-timed watchdog that issues a fixed-width reset request pulse,
// followed by a holdoff window, with a pre-timeout warning and a sticky expiry flag.
module watchdog_reset_req #(
    parameter int TIMEOUT_CYCLES = 48000000,
    parameter int WARN_CYCLES    = 36000000,
    parameter int PULSE_CYCLES   = 48,
    parameter int HOLDOFF_CYCLES = 4800
) (
    input  logic CLK_48MHZ,
    input  logic RESET,
    input  logic ENABLE,
    input  logic KICK,
    input  logic CLR_EXPIRED,
    output logic EXT_RESET_REQ,
    output logic WARN,
    output logic EXPIRED
);
    localparam int MAX_TP = TIMEOUT_CYCLES > PULSE_CYCLES ? TIMEOUT_CYCLES : PULSE_CYCLES;
    localparam int MAX_ALL = MAX_TP > HOLDOFF_CYCLES ? MAX_TP : HOLDOFF_CYCLES;
    localparam int CW = $clog2(MAX_ALL + 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] H_LAST = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [CW-1:0] W_CNT  = CW'(WARN_CYCLES);

    typedef enum logic [1:0] {IDLE, ARMED, PULSE, HOLDOFF} state_t;

    state_t state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic kick_r, kick_evt;

    assign kick_evt = KICK & ~kick_r;

    // Every state bounds the counter explicitly; count_nx defaults to zero.
    always_comb begin
        state_nx = state;
        count_nx = '0;
        case (state)
            IDLE:    state_nx = ENABLE ? ARMED : IDLE;
            ARMED: begin
                if (!ENABLE)
                    state_nx = IDLE;
                else if (kick_evt)
                    count_nx = '0;
                else if (count == T_LAST)
                    state_nx = PULSE;
                else
                    count_nx = count + CW'(1);
            end
            PULSE: begin
                if (count == P_LAST)
                    state_nx = HOLDOFF;
                else
                    count_nx = count + CW'(1);
            end
            HOLDOFF: begin
                if (count == H_LAST)
                    state_nx = ENABLE ? ARMED : IDLE;
                else
                    count_nx = count + CW'(1);
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state flops.
    always_ff @(posedge CLK_48MHZ or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            count         <= '0;
            kick_r        <= 1'b0;
            EXT_RESET_REQ <= 1'b0;
            WARN          <= 1'b0;
            EXPIRED       <= 1'b0;
        end else begin
            state         <= state_nx;
            count         <= count_nx;
            kick_r        <= KICK;
            EXT_RESET_REQ <= state_nx == PULSE;
            WARN          <= state_nx == ARMED && count_nx >= W_CNT;
            EXPIRED       <= (state == ARMED && state_nx == PULSE) | (EXPIRED & ~CLR_EXPIRED);
        end
    end
endmodule

// File: tb/tb_watchdog_reset_req.sv
// tb_watchdog_reset_req: directed checks of timeout, pulse, holdoff, warning and expiry behaviour.
module tb_watchdog_reset_req;
    logic clk = 1'b0;
    logic RESET, ENABLE, KICK, CLR_EXPIRED;
    logic EXT_RESET_REQ, WARN, EXPIRED;
    int n_chk = 0;
    int n_pass = 0;
    int n, w, bad, warn_cnt, req_cnt;

    watchdog_reset_req #(
        .TIMEOUT_CYCLES(100),
        .WARN_CYCLES(75),
        .PULSE_CYCLES(8),
        .HOLDOFF_CYCLES(20)
    ) dut (
        .CLK_48MHZ(clk),
        .RESET(RESET),
        .ENABLE(ENABLE),
        .KICK(KICK),
        .CLR_EXPIRED(CLR_EXPIRED),
        .EXT_RESET_REQ(EXT_RESET_REQ),
        .WARN(WARN),
        .EXPIRED(EXPIRED)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int cnt);
        repeat (cnt) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges until the request rises (-1 if it never does); also counts WARN-high edges before it.
    task automatic wait_req(input int max, output int edges, output int warns);
        edges = -1;
        warns = 0;
        for (int i = 1; i <= max; i++) begin
            tick(1);
            if (EXT_RESET_REQ) begin
                edges = i;
                break;
            end
            if (WARN) warns++;
        end
    endtask

    task automatic pulse_width(output int width);
        width = 0;
        while (EXT_RESET_REQ && width < 50) begin
            width++;
            tick(1);
        end
    endtask

    initial begin
        RESET = 1'b1;
        ENABLE = 1'b0;
        KICK = 1'b0;
        CLR_EXPIRED = 1'b0;
        tick(3);
        chk("reset_req", int'(EXT_RESET_REQ), 0);
        chk("reset_warn", int'(WARN), 0);
        chk("reset_expired", int'(EXPIRED), 0);
        RESET = 1'b0;
        tick(2);

        // Regular kicks every 90 clocks never expire.
        ENABLE = 1'b1;
        tick(1);
        bad = 0; warn_cnt = 0; req_cnt = 0;
        for (int p = 0; p < 11; p++) begin
            for (int i = 0; i < 89; i++) begin
                tick(1);
                warn_cnt += int'(WARN);
                req_cnt += int'(EXT_RESET_REQ);
            end
            KICK = 1'b1;
            tick(1);
            bad += int'(WARN);
            req_cnt += int'(EXT_RESET_REQ);
            KICK = 1'b0;
        end
        chk("kick_no_req", req_cnt, 0);
        chk("kick_warn_cycles", warn_cnt, 165);
        chk("kick_clears_warn", bad, 0);
        chk("kick_no_expired", int'(EXPIRED), 0);
        ENABLE = 1'b0;
        tick(1);
        chk("disable_warn", int'(WARN), 0);

        // No kicks: pulse 100 clocks after ARMED entry, 8 wide; re-armed pulse after 20+100.
        ENABLE = 1'b1;
        tick(1);
        wait_req(150, n, w);
        chk("timeout_latency", n, 100);
        chk("timeout_warn_cycles", w, 25);
        chk("timeout_expired", int'(EXPIRED), 1);
        chk("timeout_warn_off", int'(WARN), 0);
        pulse_width(w);
        chk("pulse_width", w, 8);
        chk("expired_sticky", int'(EXPIRED), 1);
        wait_req(200, n, w);
        chk("second_pulse_latency", n, 120);
        ENABLE = 1'b0;
        pulse_width(w);
        chk("pulse_width_disabled", w, 8);
        wait_req(300, n, w);
        chk("no_pulse_after_disable", n, -1);
        chk("expired_still_set", int'(EXPIRED), 1);
        CLR_EXPIRED = 1'b1;
        tick(1);
        chk("clr_expired", int'(EXPIRED), 0);
        CLR_EXPIRED = 1'b0;

        // Kick on the terminal count, then KICK held high across a full timeout cycle.
        ENABLE = 1'b1;
        tick(1);
        tick(99);
        chk("terminal_no_req_yet", int'(EXT_RESET_REQ), 0);
        KICK = 1'b1;
        tick(1);
        chk("terminal_kick_no_req", int'(EXT_RESET_REQ), 0);
        wait_req(150, n, w);
        chk("held_kick_latency", n, 100);
        pulse_width(w);
        chk("held_kick_width", w, 8);
        wait_req(200, n, w);
        chk("held_kick_rearm_latency", n, 120);
        KICK = 1'b0;
        pulse_width(w);
        ENABLE = 1'b0;
        tick(25);

        // Disable at count 50 for 10 clocks, then a full timeout from re-entry to ARMED.
        ENABLE = 1'b1;
        tick(1);
        tick(50);
        ENABLE = 1'b0;
        tick(1);
        chk("disable_mid_req", int'(EXT_RESET_REQ), 0);
        tick(9);
        chk("disabled_no_req", int'(EXT_RESET_REQ), 0);
        ENABLE = 1'b1;
        tick(1);
        wait_req(150, n, w);
        chk("reenable_latency", n, 100);

        // Asynchronous reset on the 4th clock of the pulse.
        tick(3);
        chk("pulse_clock4_req", int'(EXT_RESET_REQ), 1);
        #2 RESET = 1'b1;
        #1;
        chk("async_req_drop", int'(EXT_RESET_REQ), 0);
        chk("async_expired_drop", int'(EXPIRED), 0);
        chk("async_warn_drop", int'(WARN), 0);
        tick(1);
        RESET = 1'b0;
        tick(1);
        wait_req(150, n, w);
        chk("post_reset_latency", n, 100);
        pulse_width(w);
        ENABLE = 1'b0;
        tick(30);
        CLR_EXPIRED = 1'b1;
        tick(1);
        chk("clr_before_race", int'(EXPIRED), 0);
        CLR_EXPIRED = 1'b0;

        // CLR_EXPIRED in the same cycle as expiry: set wins.
        ENABLE = 1'b1;
        tick(1);
        tick(99);
        CLR_EXPIRED = 1'b1;
        tick(1);
        chk("race_req", int'(EXT_RESET_REQ), 1);
        chk("race_expired_set", int'(EXPIRED), 1);
        tick(1);
        chk("race_then_clear", int'(EXPIRED), 0);
        CLR_EXPIRED = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/watchdog_reset_req.md
Name: watchdog_reset_req

Overview:
- Watchdog timer on CLK_48MHZ that originates reset requests.
- Times the interval between software/firmware kicks. On timeout it drives a fixed-width, active-high request pulse into the EXT_RESET input of the board reset pulse generator.
- Provides a pre-timeout warning and a sticky expiry flag for the status register.
- Sits between the avionics control logic and the reset generator, as the requesting end of the reset path.

Parameters:
- TIMEOUT_CYCLES, 48000000, clocks without a kick before expiry (1 s at 48 MHz); must be >= 2.
- WARN_CYCLES, 36000000, count value at which WARN asserts; must be < TIMEOUT_CYCLES.
- PULSE_CYCLES, 48, width of the EXT_RESET_REQ pulse in clocks (1 us); must be >= 1.
- HOLDOFF_CYCLES, 4800, clocks after the pulse during which kicks are ignored and no new request is issued; must be >= 1.

Ports:
- CLK_48MHZ  in  1  system clock, 48 MHz.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  watchdog enable, synchronous to CLK_48MHZ, level.
- KICK  in  1  kick strobe, synchronous to CLK_48MHZ. A rising edge counts as one kick; held high counts as one kick only.
- CLR_EXPIRED  in  1  synchronous clear for EXPIRED, level.
- EXT_RESET_REQ  out  1  reset request pulse to the reset generator, registered.
- WARN  out  1  high while count >= WARN_CYCLES in ARMED, registered.
- EXPIRED  out  1  sticky; set on expiry, registered.

Behaviour:
- Reset (async, RESET=1): state=IDLE, count=0, kick edge register=0. EXT_RESET_REQ=0, WARN=0, EXPIRED=0, all immediately. Reset mid-pulse truncates the pulse at once.
- Kick detect: kick_r <= KICK each clock; kick_evt = KICK & ~kick_r. The register runs in all states, so an edge is never double-counted across a state change.
- Counter: unsigned, width clog2(max(TIMEOUT_CYCLES, PULSE_CYCLES, HOLDOFF_CYCLES)+1). It never wraps; every state bounds it explicitly.

State IDLE:
- count=0.
- If ENABLE=1, go to ARMED next cycle with count=0.

State ARMED:
- If ENABLE=0: go to IDLE, count=0. Disable takes priority over the terminal count.
- Else if kick_evt: count=0. A kick takes priority over expiry in the same cycle.
- Else if count==TIMEOUT_CYCLES-1: go to PULSE, count=0, set EXPIRED.
- Else: count+1.
- Expiry timing: with no kick, EXT_RESET_REQ rises exactly TIMEOUT_CYCLES clocks after the last kick_evt cycle, or after entry to ARMED.

State PULSE:
- EXT_RESET_REQ=1 for exactly PULSE_CYCLES clocks, then go to HOLDOFF with count=0.
- ENABLE and kicks are ignored; the pulse is never shortened except by RESET.

State HOLDOFF:
- EXT_RESET_REQ=0; kicks ignored.
- After HOLDOFF_CYCLES clocks, go to ARMED (count=0) if ENABLE=1, else IDLE.

WARN:
- Registered; WARN=1 on the cycle after count reaches WARN_CYCLES in ARMED.
- Clears the cycle after a kick_evt, a leave from ARMED, or a disable.
- WARN=0 in all other states.

EXPIRED:
- Set on the ARMED->PULSE transition.
- Cleared by CLR_EXPIRED=1. Set wins if both occur in the same cycle.

EXT_RESET_REQ:
- Comes directly from a flop; no combinational path from inputs.
- Downstream sees clean edges synchronous to CLK_48MHZ.

Test Plan:
- Bench parameters: TIMEOUT_CYCLES=100, WARN_CYCLES=75, PULSE_CYCLES=8, HOLDOFF_CYCLES=20.
- Enable, then kick every 90 clocks for 1000 clocks -> EXT_RESET_REQ never asserts, EXPIRED=0. WARN pulses high from count 75 until each kick.
- Enable, no kicks -> EXT_RESET_REQ high exactly 8 clocks starting 100 clocks after ARMED entry. EXPIRED=1 and remains 1 after the pulse. WARN high for 25 clocks before expiry.
- Kick asserted on the terminal-count cycle (count=99) -> no pulse; count restarts at 0. Also hold KICK high for 300 clocks -> only one kick, so expiry occurs 100 clocks after the edge.
- Deassert ENABLE at count=50, re-enable 10 clocks later -> no pulse. Timeout measured 100 clocks from re-enable.
- Deassert ENABLE during PULSE -> the 8-clock pulse completes, 20-clock holdoff follows, then IDLE with no second pulse. With ENABLE held high instead, a second pulse appears 20+100 clocks after the first pulse ends.
- RESET at clock 4 of the pulse -> EXT_RESET_REQ, EXPIRED and WARN drop asynchronously. After RESET release with ENABLE=1, ARMED is entered and a full 100-clock timeout is required before the next pulse.
- CLR_EXPIRED and expiry in the same cycle -> EXPIRED=1.
